// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of ALU16: register file, operand forwarding,
// load-use hazard stall and a valid/ready ID/EX pipeline register.
module alu_issue_stage #(
  parameter int DATAW = 16,
  parameter int NREG  = 8,
  parameter int REGW  = 3,
  parameter int CNTW  = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [REGW-1:0]  In_Rs,
  input  logic [REGW-1:0]  In_Rt,
  input  logic [REGW-1:0]  In_Rd,
  input  logic [3:0]       In_Op,
  input  logic             In_AInvert,
  input  logic             In_UseImm,
  input  logic [DATAW-1:0] In_Imm,
  input  logic             In_IsLoad,
  input  logic [DATAW-1:0] Alu_Result,
  input  logic             Ex_En,
  input  logic [REGW-1:0]  Ex_Rd,
  input  logic [DATAW-1:0] Ex_Data,
  input  logic             Ex_IsLoad,
  input  logic             Wb_En,
  input  logic [REGW-1:0]  Wb_Rd,
  input  logic [DATAW-1:0] Wb_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [DATAW-1:0] Out_A,
  output logic [DATAW-1:0] Out_B,
  output logic [3:0]       Out_Op,
  output logic             Out_AInvert,
  output logic [REGW-1:0]  Out_Rd,
  output logic             Out_IsLoad,
  output logic [CNTW-1:0]  StallCount
);

  logic [DATAW-1:0] rf_q [NREG];

  logic             valid_q, valid_d;
  logic [DATAW-1:0] a_q, a_d;
  logic [DATAW-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             ainv_q, ainv_d;
  logic [REGW-1:0]  rd_q, rd_d;
  logic             isload_q, isload_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [REGW-1:0]  src [2];
  logic [DATAW-1:0] opnd [2];
  logic [1:0]       src_haz;
  logic             hazard;
  logic             accept;
  logic             stall;

  assign src[0] = In_Rs;
  assign src[1] = In_Rt;

  // Forwarding priority: youngest producer first, so the ALU output beats
  // EX/MEM, which beats writeback, which beats the stored value.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      opnd[i] = rf_q[src[i]];
      if (src[i] == '0)
        opnd[i] = '0;
      else if (valid_q && rd_q == src[i] && !isload_q)
        opnd[i] = Alu_Result;
      else if (Ex_En && Ex_Rd == src[i] && !Ex_IsLoad)
        opnd[i] = Ex_Data;
      else if (Wb_En && Wb_Rd == src[i])
        opnd[i] = Wb_Data;

      src_haz[i] = (src[i] != '0) &&
                   ((valid_q && isload_q && rd_q == src[i]) ||
                    (Ex_En && Ex_IsLoad && Ex_Rd == src[i]));
    end
  end

  // Rt is not a real source when the immediate replaces operand B.
  assign hazard   = src_haz[0] | (src_haz[1] & ~In_UseImm);
  assign In_Ready = !Flush && !hazard && (!valid_q || Out_Ready);
  assign accept   = In_Valid && In_Ready;
  assign stall    = In_Valid && hazard && !Flush;

  always_comb begin
    valid_d  = valid_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    ainv_d   = ainv_q;
    rd_d     = rd_q;
    isload_d = isload_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      a_d      = opnd[0];
      b_d      = In_UseImm ? In_Imm : opnd[1];
      op_d     = In_Op;
      ainv_d   = In_AInvert;
      rd_d     = In_Rd;
      isload_d = In_IsLoad;
    end else if (Out_Ready) begin
      valid_d = 1'b0;
    end
    cnt_d = (stall && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      ainv_q   <= 1'b0;
      rd_q     <= '0;
      isload_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ainv_q   <= ainv_d;
      rd_q     <= rd_d;
      isload_q <= isload_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the register file is reset because software may read a register
  // before writing it and must see 0; this keeps it in flops, not a RAM macro.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
    end else if (Wb_En && Wb_Rd != '0) begin
      rf_q[Wb_Rd] <= Wb_Data;
    end
  end

  assign Out_Valid   = valid_q;
  assign Out_A       = a_q;
  assign Out_B       = b_q;
  assign Out_Op      = op_q;
  assign Out_AInvert = ainv_q;
  assign Out_Rd      = rd_q;
  assign Out_IsLoad  = isload_q;
  assign StallCount  = cnt_q;

endmodule
